sm_run_ctrl: RTL and testbench

Execution controller for the schoolMIPS core. It gates the CPU's clock-enable (`pc` register update and register-file write) so the core can be run, halted, single/multi-stepped or stopped on a PC breakpoint. It also counts retired instructions. It sits between the board debug interface (buttons/UART command decoder) and `sm_cpu`, and observes the CPU's `imAddr` as the current PC.

---
 rtl/sm_run_ctrl_pkg.sv | 23 ++
 rtl/sm_run_ctrl.sv | 126 ++++++++++++
 tb/tb_sm_run_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_run_ctrl_pkg.sv
// sm_run_ctrl_pkg: state and command codes shared by the schoolMIPS
// execution controller and anything that drives or observes it.
package sm_run_ctrl_pkg;

    // Controller state codes, as seen on the state output.
    localparam logic [1:0] RC_HALT  = 2'b00;
    localparam logic [1:0] RC_RUN   = 2'b01;
    localparam logic [1:0] RC_STEP  = 2'b10;
    localparam logic [1:0] RC_BREAK = 2'b11;

    // Debug command codes. 101..111 decode as NOP.
    localparam logic [2:0] RC_CMD_NOP    = 3'b000;
    localparam logic [2:0] RC_CMD_RUN    = 3'b001;
    localparam logic [2:0] RC_CMD_HALT   = 3'b010;
    localparam logic [2:0] RC_CMD_STEP   = 3'b011;
    localparam logic [2:0] RC_CMD_CLRCNT = 3'b100;

    // Step count to load: a request for zero steps still runs one.
    function automatic logic [7:0] step_load(input logic [7:0] arg);
        return (arg == 8'd0) ? 8'd1 : arg;
    endfunction

endpackage

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run/halt/step/breakpoint controller for the schoolMIPS core.
// Ports: clk, rst_n (async, active-low); cmd_valid/cmd_ready/cmd/cmd_arg
// command channel; bp_en/bp_addr breakpoint; pc = CPU imAddr; cpu_en
// clock-enable to the CPU; state/halted/bp_hit status; instret counter.
module sm_run_ctrl
    import sm_run_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd,
    input  logic [7:0]       cmd_arg,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] RESET_STATE = RESET_RUN ? RC_RUN : RC_HALT;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       skip;
    logic       skip_nxt;
    logic [7:0] step_left;
    logic [7:0] step_left_nxt;
    logic [1:0] state_nxt;
    logic       bp_match;
    logic       accept;
    logic       resume;
    logic       clr_cnt;

    // skip masks the breakpoint for the first executed instruction after
    // leaving HALT/BREAK, so resuming on the breakpoint PC makes progress.
    assign bp_match  = bp_en & (pc == bp_addr) & ~skip;
    assign cpu_en    = ((state == RC_RUN) | (state == RC_STEP)) & ~bp_match;
    assign cmd_ready = (state != RC_STEP);
    assign halted    = (state == RC_HALT) | (state == RC_BREAK);
    assign accept    = cmd_valid & cmd_ready;
    assign clr_cnt   = accept & (cmd == RC_CMD_CLRCNT);

    always_comb begin
        state_nxt     = state;
        step_left_nxt = step_left;
        unique case (state)
            RC_HALT, RC_BREAK: begin
                if (accept && cmd == RC_CMD_RUN) begin
                    state_nxt = RC_RUN;
                end else if (accept && cmd == RC_CMD_STEP) begin
                    state_nxt     = RC_STEP;
                    step_left_nxt = step_load(cmd_arg);
                end
            end
            RC_RUN: begin
                // A breakpoint overrides any command taken this cycle.
                if (bp_match) begin
                    state_nxt = RC_BREAK;
                end else if (accept && cmd == RC_CMD_HALT) begin
                    state_nxt = RC_HALT;
                end else if (accept && cmd == RC_CMD_STEP) begin
                    state_nxt     = RC_STEP;
                    step_left_nxt = step_load(cmd_arg);
                end
            end
            RC_STEP: begin
                if (bp_match) begin
                    state_nxt     = RC_BREAK;
                    step_left_nxt = 8'd0;
                end else if (cpu_en) begin
                    step_left_nxt = step_left - 8'd1;
                    if (step_left <= 8'd1) begin
                        state_nxt = RC_HALT;
                    end
                end
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // cpu_en is never high while halted, so set and clear cannot collide.
    assign resume = halted & (state_nxt != state);

    always_comb begin
        skip_nxt = skip;
        if (resume) begin
            skip_nxt = 1'b1;
        end else if (cpu_en) begin
            skip_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            skip      <= 1'b1;
            step_left <= 8'd0;
            bp_hit    <= 1'b0;
        end else begin
            state     <= state_nxt;
            skip      <= skip_nxt;
            step_left <= step_left_nxt;
            bp_hit    <= (state_nxt == RC_BREAK) & (state != RC_BREAK);
        end
    end

    // Clear beats the increment of the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (clr_cnt) begin
            instret <= '0;
        end else if (cpu_en) begin
            instret <= instret + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb_sm_run_ctrl: directed bench for sm_run_ctrl with a cycle-tagged
// scoreboard; a 4-bit counter instance covers instret wrap.
module tb_sm_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd;
    logic [7:0]  cmd_arg;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic        bp_hit;
    logic [31:0] instret;

    logic        b_ready;
    logic        b_cpu_en;
    logic [1:0]  b_state;
    logic        b_halted;
    logic        b_bp_hit;
    logic [3:0]  b_instret;

    sm_run_ctrl #(.CNT_W(32), .RESET_RUN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_arg(cmd_arg),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(cpu_en), .state(state), .halted(halted),
        .bp_hit(bp_hit), .instret(instret)
    );

    sm_run_ctrl #(.CNT_W(4), .RESET_RUN(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_b),
        .cmd_valid(1'b0), .cmd_ready(b_ready),
        .cmd(3'b000), .cmd_arg(8'd0),
        .bp_en(1'b0), .bp_addr(32'd0), .pc(32'd0),
        .cpu_en(b_cpu_en), .state(b_state), .halted(b_halted),
        .bp_hit(b_bp_hit), .instret(b_instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(input int sel);
        case (sel)
            0: return {30'd0, state};
            1: return {31'd0, cpu_en};
            2: return {31'd0, cmd_ready};
            3: return {31'd0, halted};
            4: return {31'd0, bp_hit};
            5: return instret;
            6: return {28'd0, b_instret};
            7: return {30'd0, b_state};
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: at each falling edge compare every entry due this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                tests++;
                if (act(q[i].sel) !== q[i].val) begin
                    fails++;
                    $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                             q[i].name, cyc, act(q[i].sel), q[i].val);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s missed cyc=%0d", q[i].name, q[i].cyc);
                q.delete(i);
            end
        end
    end

    task automatic ex(input int sel, input logic [31:0] v, input string n);
        chk_t c;
        c.cyc = cyc; c.sel = sel; c.val = v; c.name = n;
        q.push_back(c);
    endtask

    task automatic ex_at(input int at, input int sel, input logic [31:0] v,
                         input string n);
        chk_t c;
        c.cyc = at; c.sel = sel; c.val = v; c.name = n;
        q.push_back(c);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] a);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_arg   = a;
    endtask

    initial begin
        rst_n = 1'b0; rst_b = 1'b0;
        cmd_valid = 1'b0; cmd = 3'd0; cmd_arg = 8'd0;
        bp_en = 1'b0; bp_addr = 32'd0; pc = 32'd0;

        tick;
        ex(0, 0, "rst_state"); ex(1, 0, "rst_cpu_en");
        ex(2, 1, "rst_ready"); ex(3, 1, "rst_halted");
        ex(4, 0, "rst_bp_hit"); ex(5, 0, "rst_instret");
        tick;
        rst_n = 1'b1; rst_b = 1'b1;
        // Wrap instance runs from this cycle on; +16 -> 0, +17 -> 1.
        ex(7, 1, "w_rst_run");
        ex_at(cyc + 16, 6, 0, "w_wrap0");
        ex_at(cyc + 17, 6, 1, "w_wrap1");

        // RUN from HALT.
        issue(3'b001, 8'd0);
        ex(0, 0, "run_pre_state"); ex(1, 0, "run_pre_en");
        tick; cmd_valid = 1'b0;
        ex(0, 1, "run_state");
        for (int i = 0; i < 5; i++) begin
            pc = i;
            ex(1, 1, "run_en");
            tick;
        end
        pc = 5;
        ex(5, 5, "run_instret5");
        issue(3'b010, 8'd0);
        ex(1, 1, "halt_last_exec");
        tick; cmd_valid = 1'b0;
        ex(0, 0, "halt_state"); ex(5, 6, "halt_instret");
        ex(3, 1, "halt_halted"); ex(1, 0, "halt_en");

        // STEP 3 with a HALT held off while stepping.
        issue(3'b011, 8'd3);
        tick;
        issue(3'b010, 8'd0);
        for (int k = 0; k < 3; k++) begin
            pc = 6 + k;
            ex(0, 2, "step3_state"); ex(2, 0, "step3_ready");
            ex(1, 1, "step3_en");
            tick;
        end
        cmd_valid = 1'b0; pc = 9;
        ex(0, 0, "step3_done"); ex(1, 0, "step3_en_off");
        ex(5, 9, "step3_instret");

        // STEP 0 behaves as STEP 1.
        issue(3'b011, 8'd0);
        tick; cmd_valid = 1'b0;
        ex(0, 2, "step0_state"); ex(1, 1, "step0_en");
        tick; pc = 10;
        ex(0, 0, "step0_done"); ex(5, 10, "step0_instret");

        // Breakpoint at 0x10 while running.
        bp_en = 1'b1; bp_addr = 32'h10;
        issue(3'b001, 8'd0);
        tick; cmd_valid = 1'b0;
        for (int i = 10; i < 16; i++) begin
            pc = i;
            ex(1, 1, "bp_pre_en");
            tick;
        end
        pc = 32'h10;
        ex(1, 0, "bp_match_en"); ex(0, 1, "bp_match_state");
        tick;
        ex(0, 3, "bp_state"); ex(4, 1, "bp_hit_pulse");
        ex(3, 1, "bp_halted"); ex(5, 16, "bp_instret");
        tick;
        ex(4, 0, "bp_hit_once"); ex(0, 3, "bp_state_hold");

        // Resume at the breakpoint, then loop back to it.
        issue(3'b001, 8'd0);
        tick; cmd_valid = 1'b0;
        ex(0, 1, "res_state"); ex(1, 1, "res_skip_en");
        tick; pc = 32'h11;
        ex(1, 1, "res_next_en");
        tick; pc = 32'h10;
        ex(1, 0, "rebreak_en");
        tick;
        ex(0, 3, "rebreak_state"); ex(4, 1, "rebreak_hit");
        ex(5, 18, "rebreak_instret");

        // HALT accepted in the same cycle as a breakpoint match.
        issue(3'b001, 8'd0);
        tick; cmd_valid = 1'b0;
        tick; pc = 32'h11;
        tick; pc = 32'h10;
        issue(3'b010, 8'd0);
        ex(1, 0, "hb_en"); ex(2, 1, "hb_ready");
        tick; cmd_valid = 1'b0;
        ex(0, 3, "hb_state"); ex(4, 1, "hb_hit");
        ex(5, 20, "hb_instret");

        // CLRCNT in a cpu_en cycle.
        issue(3'b001, 8'd0);
        tick; cmd_valid = 1'b0;
        tick; pc = 32'h11;
        issue(3'b100, 8'd0);
        ex(5, 21, "clr_pre"); ex(1, 1, "clr_en");
        tick; pc = 32'h12;
        issue(3'b111, 8'd0);
        ex(5, 0, "clr_zero"); ex(0, 1, "clr_no_state");
        tick; pc = 32'h13;
        ex(5, 1, "clr_count"); ex(0, 1, "nop7_state");
        issue(3'b010, 8'd0);
        tick; cmd_valid = 1'b0;
        ex(0, 0, "clr_halt"); ex(5, 2, "clr_instret");

        // Reset asserted mid-STEP.
        bp_en = 1'b0;
        issue(3'b011, 8'd5);
        tick; cmd_valid = 1'b0;
        ex(0, 2, "ms_state");
        tick;
        rst_n = 1'b0;
        #1;
        ex(0, 0, "ms_rst_state"); ex(1, 0, "ms_rst_en");
        ex(2, 1, "ms_rst_ready"); ex(5, 0, "ms_rst_instret");
        ex(3, 1, "ms_rst_halted");
        tick;
        rst_n = 1'b1;
        tick;
        ex(0, 0, "ms_after_state"); ex(1, 0, "ms_after_en");

        for (int w = 0; w < 200 && q.size() != 0; w++) tick;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
